// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/reset sequencer: FSM states, run result record and channel-mask helpers.
package run_ctrl_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned MAX_CH    = 32;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        FINISH
    } state_t;

    typedef logic [MAX_CH-1:0] ch_mask_t;

    typedef struct packed {
        logic     pass;
        logic     timeout;
        ch_mask_t done_mask;
    } result_t;

    // Ones for the channels that exist; padding bits count as already done.
    function automatic ch_mask_t ch_valid(input int unsigned n);
        ch_mask_t m;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/reset sequencer: holds the system in reset, counts run cycles, reports pass/fail/timeout.
// Optional per-channel completion timestamps on done_cyc_o when RUN_CTRL_PERF_EN is defined.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned RST_HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 200,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] done_i,
    input  logic [NUM_CH-1:0] fail_i,
    output logic              dut_rst_o,
    output logic              running_o,
    output logic              finished_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [NUM_CH-1:0] done_mask_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
`ifdef RUN_CTRL_PERF_EN
    ,
    output logic [NUM_CH-1:0][CNT_W-1:0] done_cyc_o
`endif
);

    localparam int unsigned     HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam ch_mask_t          CH_VALID  = ch_valid(NUM_CH);

    state_t              state_q, state_nxt;
    logic [HOLD_W-1:0]   hold_q, hold_nxt;
    result_t             res_q, res_nxt;
    ch_mask_t            next_mask;
    logic                all_done;
    logic                run_entry;
    logic                cnt_clr;
    logic                cnt_en;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cycle_cnt_o)
    );

    assign run_entry = (state_q == HOLD) && (hold_q == '0);

    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        res_nxt   = res_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        next_mask = res_q.done_mask | ch_mask_t'(done_i);
        all_done  = &(next_mask | ~CH_VALID);

        case (state_q)
            IDLE, FINISH: begin
                if (start_i) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                    res_nxt   = '0;
                    cnt_clr   = 1'b1;
                end
            end
            HOLD: begin
                if (run_entry) begin
                    state_nxt = RUN;
                    res_nxt   = '0;
                    cnt_clr   = 1'b1;
                end else begin
                    hold_nxt = hold_q - 1'b1;
                end
            end
            RUN: begin
                // The exiting cycle still counts and still records its done pulses.
                cnt_en            = 1'b1;
                res_nxt.done_mask = next_mask;
                if (|fail_i) begin
                    state_nxt = FINISH;
                end else if (all_done) begin
                    state_nxt    = FINISH;
                    res_nxt.pass = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (cycle_cnt_o == TO_LAST)) begin
                    state_nxt       = FINISH;
                    res_nxt.timeout = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            res_q      <= '0;
            dut_rst_o  <= 1'b1;
            running_o  <= 1'b0;
            finished_o <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            hold_q     <= hold_nxt;
            res_q      <= res_nxt;
            dut_rst_o  <= (state_nxt == IDLE) || (state_nxt == HOLD);
            running_o  <= (state_nxt == RUN);
            finished_o <= (state_nxt == FINISH);
        end
    end

    assign pass_o      = res_q.pass;
    assign timeout_o   = res_q.timeout;
    assign done_mask_o = res_q.done_mask[NUM_CH-1:0];

`ifdef RUN_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_stamp;

    assign cyc_stamp = (cycle_cnt_o == {CNT_W{1'b1}}) ? cycle_cnt_o : cycle_cnt_o + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_cyc_o <= '0;
        end else if (run_entry) begin
            done_cyc_o <= '0;
        end else if (state_q == RUN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (done_i[c] && !res_q.done_mask[c]) begin
                    done_cyc_o[c] <= cyc_stamp;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_run_controller.sv
// Table-driven bench for run_controller with a scoreboard of expected run results.
module tb_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  done_i = 2'b00;
    logic [1:0]  fail_i = 2'b00;
    logic        dut_rst_o, running_o, finished_o, pass_o, timeout_o;
    logic [1:0]  done_mask_o;
    logic [31:0] cycle_cnt_o;
`ifdef RUN_CTRL_PERF_EN
    logic [1:0][31:0] done_cyc_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         d0;
        int         d1;
        int         fcyc;
        logic [1:0] fmask;
        logic       pass;
        logic       to;
        logic [1:0] mask;
        int         cnt;
        int         dc0;
        int         dc1;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    run_controller #(
        .NUM_CH          (2),
        .RST_HOLD_CYCLES (2),
        .TIMEOUT_CYCLES  (200),
        .CNT_W           (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .done_i      (done_i),
        .fail_i      (fail_i),
        .dut_rst_o   (dut_rst_o),
        .running_o   (running_o),
        .finished_o  (finished_o),
        .pass_o      (pass_o),
        .timeout_o   (timeout_o),
        .done_mask_o (done_mask_o),
        .cycle_cnt_o (cycle_cnt_o)
`ifdef RUN_CTRL_PERF_EN
        ,
        .done_cyc_o  (done_cyc_o)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_dut_rst"}, dut_rst_o, 1);
        chk({tag, "_running"}, running_o, 0);
        chk({tag, "_finished"}, finished_o, 0);
        chk({tag, "_pass"}, pass_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_mask"}, done_mask_o, 0);
        chk({tag, "_cnt"}, cycle_cnt_o, 0);
    endtask

    // Pulse start, check the two-cycle reset hold, then drive the row's done/fail schedule.
    task automatic do_run(input vec_t v, input bit from_finish);
        vec_t e;
        int   cyc;
        sb_q.push_back(v);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        if (from_finish) begin
            chk("restart_finished", finished_o, 0);
            chk("restart_pass", pass_o, 0);
            chk("restart_mask", done_mask_o, 0);
            chk("restart_cnt", cycle_cnt_o, 0);
        end
        chk("hold1_dut_rst", dut_rst_o, 1);
        chk("hold1_running", running_o, 0);
        tick();
        chk("hold2_dut_rst", dut_rst_o, 1);
        tick();
        chk("run1_dut_rst", dut_rst_o, 0);
        chk("run1_running", running_o, 1);
        chk("run1_cnt", cycle_cnt_o, 0);

        cyc = 1;
        while (!finished_o && cyc <= 300) begin
            done_i[0] = (cyc == v.d0);
            done_i[1] = (cyc == v.d1);
            fail_i    = (cyc == v.fcyc) ? v.fmask : 2'b00;
            start_i   = (cyc == 5);
            tick();
            cyc++;
        end
        done_i  = 2'b00;
        fail_i  = 2'b00;
        start_i = 1'b0;

        if (!finished_o) begin
            checks++;
            errors++;
            $display("FAIL run_end actual=not_finished required=finished");
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard actual=empty required=entry");
        end else begin
            e = sb_q.pop_front();
            chk("fin_pass", pass_o, e.pass);
            chk("fin_timeout", timeout_o, e.to);
            chk("fin_mask", done_mask_o, e.mask);
            chk("fin_cnt", cycle_cnt_o, e.cnt);
            chk("fin_dut_rst", dut_rst_o, 0);
`ifdef RUN_CTRL_PERF_EN
            chk("fin_done_cyc0", done_cyc_o[0], e.dc0);
            chk("fin_done_cyc1", done_cyc_o[1], e.dc1);
`endif
            done_i = 2'b11;
            fail_i = 2'b11;
            repeat (3) tick();
            done_i = 2'b00;
            fail_i = 2'b00;
            chk("frozen_finished", finished_o, 1);
            chk("frozen_pass", pass_o, e.pass);
            chk("frozen_mask", done_mask_o, e.mask);
            chk("frozen_cnt", cycle_cnt_o, e.cnt);
        end
    endtask

    initial begin
        //           d0   d1   fcyc fmask  pass to mask   cnt  dc0  dc1
        vecs[0] = '{ 10,  25,  0,   2'b00, 1,   0, 2'b11, 25,  10,  25 };
        vecs[1] = '{ 10,  0,   0,   2'b00, 0,   1, 2'b01, 200, 10,  0  };
        vecs[2] = '{ 7,   7,   7,   2'b10, 0,   0, 2'b11, 7,   7,   7  };
        vecs[3] = '{ 1,   1,   0,   2'b00, 1,   0, 2'b11, 1,   1,   1  };
        vecs[4] = '{ 0,   2,   3,   2'b01, 0,   0, 2'b10, 3,   0,   2  };
        vecs[5] = '{ 200, 199, 0,   2'b00, 1,   0, 2'b11, 200, 200, 199};
        vecs[6] = '{ 0,   0,   200, 2'b01, 0,   0, 2'b00, 200, 0,   0  };

        rst = 1'b0;
        repeat (2) tick();
        check_idle("reset");
        rst = 1'b1;
        tick();
        chk("idle_dut_rst", dut_rst_o, 1);

        for (int i = 0; i < 7; i++) begin
            do_run(vecs[i], i != 0);
        end

        // Reset in RUN cycle 50 aborts immediately.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        chk("abort_running", running_o, 1);
        for (int cyc = 1; cyc < 50; cyc++) begin
            done_i[0] = (cyc == 10);
            tick();
        end
        done_i = 2'b00;
        chk("abort_pre_cnt", cycle_cnt_o, 49);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle("abort");

        do_run(vecs[0], 1'b0);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Synthesizable run/reset sequencer that brings the RISC-V + GEMM system out of reset and decides when a run has ended. It replaces fixed reset-wait and fixed cycle-count sequencing with a parametrised controller:
- holds the DUT in reset for a configurable number of cycles;
- counts run cycles;
- watches NUM_CH completion/failure sources (core, GEMM accelerator, ...);
- reports pass, fail or timeout, plus the cycle count.

It sits between the top-level clock/reset and the system top, and can be re-armed for back-to-back runs.

Parameters:
NUM_CH, 2, number of independent done/fail sources (>=1).
RST_HOLD_CYCLES, 2, cycles dut_rst_o stays asserted after start (>=1).
TIMEOUT_CYCLES, 200, maximum RUN cycles before timeout; 0 disables timeout.
CNT_W, 32, width of the cycle counter.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-low reset.
start_i  in  1  single-cycle pulse; arms a run.
done_i  in  NUM_CH  per-channel completion pulse or level.
fail_i  in  NUM_CH  per-channel failure indication.
dut_rst_o  out  1  active-high reset to the system top.
running_o  out  1  high while in RUN.
finished_o  out  1  high while in FINISH.
pass_o  out  1  valid when finished_o=1.
timeout_o  out  1  valid when finished_o=1.
done_mask_o  out  NUM_CH  sticky record of channels that have signalled done.
cycle_cnt_o  out  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, dut_rst_o=1.
  - running_o, finished_o, pass_o and timeout_o are 0.
  - done_mask_o=0, cycle_cnt_o=0, hold counter=0.
  - Reset mid-run aborts the run immediately at that edge.
- States are IDLE, HOLD, RUN and FINISH.
- IDLE:
  - dut_rst_o=1.
  - start_i=1 -> HOLD; hold counter loads RST_HOLD_CYCLES-1.
- HOLD:
  - dut_rst_o=1; counter decrements each cycle.
  - When the counter is 0 -> RUN, with cycle_cnt and done_mask cleared.
  - dut_rst_o is therefore high for exactly RST_HOLD_CYCLES cycles after the start edge.
  - start_i is ignored.
- RUN:
  - dut_rst_o=0, running_o=1.
  - cycle_cnt increments every cycle and saturates at all-ones.
  - done_mask |= done_i.
  - Exit conditions are evaluated each cycle on next_mask = done_mask|done_i. Priority is fail > done > timeout:
    - Any fail_i -> FINISH, pass=0, timeout=0.
    - Else next_mask all ones -> FINISH, pass=1.
    - Else TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 -> FINISH, timeout=1, pass=0.
  - The exiting cycle's increment and mask update are both committed.
  - So in FINISH, cycle_cnt_o equals the number of RUN cycles; on timeout it equals TIMEOUT_CYCLES.
  - start_i is ignored.
- FINISH:
  - finished_o=1; pass_o, timeout_o, done_mask_o and cycle_cnt_o are frozen.
  - dut_rst_o=0, so DUT state stays inspectable.
  - done_i and fail_i are ignored.
  - start_i=1 -> HOLD; results are cleared and dut_rst_o=1 from the next cycle.
- Outputs are registered; no combinational input-to-output paths.
- A channel whose done_i arrives in the same cycle as another channel's fail_i is recorded in done_mask_o, but the run fails.

Optional Feature:
RUN_CTRL_PERF_EN:
- When defined:
  - Adds output done_cyc_o [NUM_CH][CNT_W].
  - Each entry latches cycle_cnt+1 on that channel's first done in RUN, and is 0 if the channel never finished.
  - Entries are cleared on entering RUN and frozen in FINISH.
- When undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package run_ctrl_pkg:
  - state enum typedef (IDLE, HOLD, RUN, FINISH);
  - result struct {pass, timeout, done_mask};
  - localparam for the saturating max count.
- One natural sub-module: sat_counter (clear, enable, saturating up-count, width CNT_W), used for cycle_cnt and optionally per-channel timestamps.

Test Plan:
1. rst=0 for 2 cycles then 1, start_i pulse with defaults -> dut_rst_o high exactly 2 cycles after start, then running_o=1 with cycle_cnt_o=0 on the first RUN cycle.
2. done_i[0] in RUN cycle 10 and done_i[1] in cycle 25 -> finished_o=1, pass_o=1, done_mask_o=2'b11, cycle_cnt_o=25.
3. done_i[0] only, TIMEOUT_CYCLES=200 -> timeout_o=1, pass_o=0, cycle_cnt_o=200, done_mask_o=2'b01.
4. fail_i[1] and done_i=2'b11 in the same cycle 7 -> pass_o=0, timeout_o=0, cycle_cnt_o=7.
5. rst=0 during RUN cycle 50 -> next cycle in IDLE, dut_rst_o=1, all status outputs 0; start_i re-runs normally. start_i pulsed mid-RUN -> no effect.
6. start_i in FINISH -> results cleared, new HOLD/RUN sequence. With RUN_CTRL_PERF_EN and done at cycles 10/25 -> done_cyc_o={25,10}.
